wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-002 SHALL have ports: stall0  in  1  WB hold (instruction does not retire this cycle).
REQ-003 SHALL have ports: MEM_WB_wreg_data, MEM_WB_whi_data, MEM_WB_wlo_data, MEM_WB_wcp0_data, MEM_WB_hi_i_sel_data, MEM_WB_lo_i_sel_data, MEM_WB_SC_result_sel_data  in  1 each  MEM/WB control bits.
REQ-004 SHALL have ports: MEM_WB_result_sel_data  in  2; MEM_WB_load_type_data, MEM_WB_byte_valid_data  in  4; MEM_WB_regdst_data  in  5.
REQ-005 SHALL have ports: MEM_WB_rf_rdata0_fw_data, MEM_WB_rf_rdata1_fw_data, MEM_WB_ALU_result_data, MEM_WB_mem_rdata_data  in  32; MEM_WB_MulDiv_result_data  in  64.
REQ-006 SHALL have ports: rf_wen  out  1; rf_waddr  out  5; rf_wdata  out  32  RF write port.
REQ-007 SHALL have ports: hi_o, lo_o  out  32  architectural HI/LO with same-cycle bypass; cp0_wen  out  1; cp0_waddr  out  5; cp0_wdata  out  32.
REQ-008 SHALL have ports: wb_fw_valid  out  1; wb_fw_addr  out  5; wb_fw_data  out  32  registered last-write bypass for ID.

Function
REQ-009 commit = ~stall0; all architectural writes SHALL occur only when commit=1.
REQ-010 Load extraction: addr = MEM_WB_ALU_result_data[1:0], little-endian; load_type 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, other values SHALL be treated as LW.
REQ-011 LB/LBU SHALL select byte addr, sign/zero extend to 32; LH/LHU SHALL select halfword addr[1], sign/zero extend.
REQ-012 LWL/LWR: byte i of load data = byte_valid[i] ? shifted mem_rdata byte i : rf_rdata1_fw byte i; LWL shift left by 8*(3-addr), LWR shift right by 8*addr.
REQ-013 rf_wdata mux: SC_result_sel=1 -> 32'd1 (overrides); else result_sel 0 ALU_result, 1 load data, 2 MulDiv_result[31:0], 3 ALU_result.
REQ-014 rf_wen = MEM_WB_wreg_data & commit & (regdst != 0); rf_waddr = regdst; combinational.
REQ-015 HI register SHALL load on posedge when whi & commit: hi_i_sel=0 -> MulDiv_result[63:32], 1 -> rf_rdata0_fw; LO likewise with wlo, lo_i_sel, MulDiv_result[31:0].
REQ-016 hi_o/lo_o SHALL equal the value being written when the corresponding write is active this cycle, else the register; whi and wlo together SHALL both update.
REQ-017 cp0_wen = wcp0 & commit; cp0_waddr = regdst; cp0_wdata = rf_rdata1_fw.
REQ-018 wb_fw_* SHALL register {rf_wen, rf_waddr, rf_wdata} each posedge; valid=0 the cycle after a non-writing or stalled cycle.
REQ-019 Stall held N cycles SHALL produce no writes until the cycle stall0 drops; exactly one write then.
REQ-020 Latency: RF/CP0 write strobes 0 cycles (combinational); HI/LO, wb_fw visible next cycle.

Reset
REQ-021 On rst_n=0, asynchronously: HI=0, LO=0, wb_fw_valid=0, wb_fw_addr=0, wb_fw_data=0.
REQ-022 Reset asserted mid-stall SHALL discard pending HI/LO write; combinational outputs follow inputs during reset.

Verification
REQ-023 LB, addr=2, mem_rdata=0x1280_FF00, wreg=1, regdst=5, result_sel=1 -> rf_wen=1, rf_wdata=0xFFFF_FF80.
REQ-024 LWL addr=1, byte_valid=4'b1100, mem=0xAABB_CCDD, rt=0x1122_3344 -> rf_wdata=0xCCDD_3344.
REQ-025 whi=wlo=1, sel=0, MulDiv=0x0000_0001_FFFF_FFFE -> same cycle hi_o=1, lo_o=0xFFFF_FFFE; held after.
REQ-026 wreg=1, regdst=0, ALU=0x55 -> rf_wen=0; next cycle wb_fw_valid=0.
REQ-027 stall0=1 for 3 cycles with whi=1, rf_rdata0=0x1234 -> no HI change; stall0=0 -> HI=0x1234 next cycle.
REQ-028 SC_result_sel=1, result_sel=0, ALU=0x99 -> rf_wdata=1; rst_n pulse -> HI=LO=0, wb_fw_valid=0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage.
// Takes the MEM/WB pipeline register contents and produces the register file write,
// the CP0 write, the architectural HI/LO registers and a registered bypass of the last
// RF write for the decode stage.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall0                      hold WB; nothing retires while high
//   MEM_WB_*                    control and data from the MEM/WB pipeline register
//   rf_wen/rf_waddr/rf_wdata    register file write port (combinational)
//   hi_o/lo_o                   HI/LO with same-cycle bypass of an active write
//   cp0_wen/cp0_waddr/cp0_wdata CP0 write port (combinational)
//   wb_fw_valid/addr/data       last RF write, registered, for ID forwarding
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall0,
  input  logic        MEM_WB_wreg_data,
  input  logic        MEM_WB_whi_data,
  input  logic        MEM_WB_wlo_data,
  input  logic        MEM_WB_wcp0_data,
  input  logic        MEM_WB_hi_i_sel_data,
  input  logic        MEM_WB_lo_i_sel_data,
  input  logic        MEM_WB_SC_result_sel_data,
  input  logic [1:0]  MEM_WB_result_sel_data,
  input  logic [3:0]  MEM_WB_load_type_data,
  input  logic [3:0]  MEM_WB_byte_valid_data,
  input  logic [4:0]  MEM_WB_regdst_data,
  input  logic [31:0] MEM_WB_rf_rdata0_fw_data,
  input  logic [31:0] MEM_WB_rf_rdata1_fw_data,
  input  logic [31:0] MEM_WB_ALU_result_data,
  input  logic [31:0] MEM_WB_mem_rdata_data,
  input  logic [63:0] MEM_WB_MulDiv_result_data,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        cp0_wen,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        wb_fw_valid,
  output logic [4:0]  wb_fw_addr,
  output logic [31:0] wb_fw_data
);

  localparam logic [3:0] LdLw  = 4'd0;
  localparam logic [3:0] LdLb  = 4'd1;
  localparam logic [3:0] LdLbu = 4'd2;
  localparam logic [3:0] LdLh  = 4'd3;
  localparam logic [3:0] LdLhu = 4'd4;
  localparam logic [3:0] LdLwl = 4'd5;
  localparam logic [3:0] LdLwr = 4'd6;

  logic        commit;
  logic [1:0]  addr;
  logic [31:0] byte_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] lwl_shifted;
  logic [31:0] lwr_shifted;
  logic [31:0] lwl_merged;
  logic [31:0] lwr_merged;
  logic [31:0] load_data;

  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_new;
  logic [31:0] lo_new;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        fw_valid_q;
  logic [4:0]  fw_addr_q;
  logic [31:0] fw_data_q;

  assign commit = ~stall0;
  assign addr   = MEM_WB_ALU_result_data[1:0];

  // Load data extraction (little-endian byte lanes).
  always_comb begin
    byte_shifted = MEM_WB_mem_rdata_data >> {addr, 3'b000};
    ld_byte      = byte_shifted[7:0];
    ld_half      = addr[1] ? MEM_WB_mem_rdata_data[31:16] : MEM_WB_mem_rdata_data[15:0];
    // ~addr == 3 - addr for a 2-bit address.
    lwl_shifted  = MEM_WB_mem_rdata_data << {~addr, 3'b000};
    lwr_shifted  = MEM_WB_mem_rdata_data >> {addr, 3'b000};
    lwl_merged   = MEM_WB_rf_rdata1_fw_data;
    lwr_merged   = MEM_WB_rf_rdata1_fw_data;
    for (int i = 0; i < 4; i++) begin
      if (MEM_WB_byte_valid_data[i]) begin
        lwl_merged[8*i +: 8] = lwl_shifted[8*i +: 8];
        lwr_merged[8*i +: 8] = lwr_shifted[8*i +: 8];
      end
    end

    load_data = MEM_WB_mem_rdata_data;
    case (MEM_WB_load_type_data)
      LdLw:    load_data = MEM_WB_mem_rdata_data;
      LdLb:    load_data = {{24{ld_byte[7]}}, ld_byte};
      LdLbu:   load_data = {24'd0, ld_byte};
      LdLh:    load_data = {{16{ld_half[15]}}, ld_half};
      LdLhu:   load_data = {16'd0, ld_half};
      LdLwl:   load_data = lwl_merged;
      LdLwr:   load_data = lwr_merged;
      default: load_data = MEM_WB_mem_rdata_data;
    endcase
  end

  // RF write port; SC success overrides the result select.
  always_comb begin
    rf_wdata = MEM_WB_ALU_result_data;
    if (MEM_WB_SC_result_sel_data) begin
      rf_wdata = 32'd1;
    end else begin
      case (MEM_WB_result_sel_data)
        2'd0:    rf_wdata = MEM_WB_ALU_result_data;
        2'd1:    rf_wdata = load_data;
        2'd2:    rf_wdata = MEM_WB_MulDiv_result_data[31:0];
        default: rf_wdata = MEM_WB_ALU_result_data;
      endcase
    end
  end

  assign rf_wen    = MEM_WB_wreg_data & commit & (MEM_WB_regdst_data != 5'd0);
  assign rf_waddr  = MEM_WB_regdst_data;

  assign cp0_wen   = MEM_WB_wcp0_data & commit;
  assign cp0_waddr = MEM_WB_regdst_data;
  assign cp0_wdata = MEM_WB_rf_rdata1_fw_data;

  // HI/LO
  assign hi_we  = MEM_WB_whi_data & commit;
  assign lo_we  = MEM_WB_wlo_data & commit;
  assign hi_new = MEM_WB_hi_i_sel_data ? MEM_WB_rf_rdata0_fw_data
                                       : MEM_WB_MulDiv_result_data[63:32];
  assign lo_new = MEM_WB_lo_i_sel_data ? MEM_WB_rf_rdata0_fw_data
                                       : MEM_WB_MulDiv_result_data[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (hi_we) hi_q <= hi_new;
      if (lo_we) lo_q <= lo_new;
    end
  end

  // Same-cycle bypass so a MFHI/MFLO reading this cycle sees the retiring value.
  assign hi_o = hi_we ? hi_new : hi_q;
  assign lo_o = lo_we ? lo_new : lo_q;

  // Registered copy of the RF write for ID-stage forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw_valid_q <= 1'b0;
      fw_addr_q  <= 5'd0;
      fw_data_q  <= 32'd0;
    end else begin
      fw_valid_q <= rf_wen;
      fw_addr_q  <= rf_waddr;
      fw_data_q  <= rf_wdata;
    end
  end

  assign wb_fw_valid = fw_valid_q;
  assign wb_fw_addr  = fw_addr_q;
  assign wb_fw_data  = fw_data_q;

endmodule
